// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rtc_pkg
// Brief   : Shared definitions for the RTC multiplexed-bus controllers:
//           register addresses, transfer command, FSM state encoding and the
//           index -> address lookup used by the read sweep.
// Revision: 1.0 - initial release
// ============================================================================
package rtc_pkg;

    // RTC time-register addresses, in sweep order
    localparam logic [7:0] c_dir_seg      = 8'h21;
    localparam logic [7:0] c_dir_min      = 8'h22;
    localparam logic [7:0] c_dir_hora     = 8'h23;
    localparam logic [7:0] c_dir_dia      = 8'h24;
    localparam logic [7:0] c_dir_mes      = 8'h25;
    localparam logic [7:0] c_dir_anio     = 8'h26;

    // Transfer command: written as both address and data byte
    localparam logic [7:0] c_cmd_transfer = 8'hF0;

    // Index of the last register in the sweep (anio)
    localparam logic [2:0] c_idx_ultimo   = 3'd5;

    // Read-controller state encoding
    typedef logic [3:0] estado_t;

    localparam estado_t c_est_idle  = 4'd0;
    localparam estado_t c_est_tr_a  = 4'd1;
    localparam estado_t c_est_tr_wa = 4'd2;
    localparam estado_t c_est_tr_d  = 4'd3;
    localparam estado_t c_est_tr_wd = 4'd4;
    localparam estado_t c_est_rd_a  = 4'd5;
    localparam estado_t c_est_rd_wa = 4'd6;
    localparam estado_t c_est_rd_d  = 4'd7;
    localparam estado_t c_est_rd_wd = 4'd8;
    localparam estado_t c_est_fin   = 4'd9;
    localparam estado_t c_est_err   = 4'd10;

    // Address of the time register selected by the sweep index
    function automatic logic [7:0] tabla(input logic [2:0] idx);
        logic [7:0] dir;
        case (idx)
            3'd0:    dir = c_dir_seg;
            3'd1:    dir = c_dir_min;
            3'd2:    dir = c_dir_hora;
            3'd3:    dir = c_dir_dia;
            3'd4:    dir = c_dir_mes;
            3'd5:    dir = c_dir_anio;
            default: dir = 8'h00;
        endcase
        return dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/deco_leer.sv
`default_nettype none
// ============================================================================
// Module  : deco_leer
// Brief   : Moore output decoder for the read controller. Maps the current
//           state and sweep index onto the bus-cycle request and the
//           op/ad/byte fields presented to the bus-cycle generator.
// Revision: 1.0 - initial release
// ============================================================================
module deco_leer
    import rtc_pkg::*;
(
    input  estado_t    i_estado,
    input  logic [2:0] i_idx,
    output logic       o_op_r,
    output logic       o_ad_r,
    output logic [7:0] o_bus_out,
    output logic       o_inicio_wr
);

    // Fields depend only on state (and index), so they stay constant from
    // each request state through its wait state.
    always_comb begin
        o_op_r      = 1'b0;
        o_ad_r      = 1'b0;
        o_bus_out   = 8'h00;
        o_inicio_wr = 1'b0;
        case (i_estado)
            c_est_tr_a: begin
                o_inicio_wr = 1'b1;
                o_ad_r      = 1'b1;
                o_bus_out   = c_cmd_transfer;
            end
            c_est_tr_wa: begin
                o_ad_r      = 1'b1;
                o_bus_out   = c_cmd_transfer;
            end
            c_est_tr_d: begin
                o_inicio_wr = 1'b1;
                o_bus_out   = c_cmd_transfer;
            end
            c_est_tr_wd: begin
                o_bus_out   = c_cmd_transfer;
            end
            c_est_rd_a: begin
                o_inicio_wr = 1'b1;
                o_ad_r      = 1'b1;
                o_bus_out   = tabla(i_idx);
            end
            c_est_rd_wa: begin
                o_ad_r      = 1'b1;
                o_bus_out   = tabla(i_idx);
            end
            c_est_rd_d: begin
                o_inicio_wr = 1'b1;
                o_op_r      = 1'b1;
            end
            c_est_rd_wd: begin
                o_op_r      = 1'b1;
            end
            default: begin
                o_op_r      = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_leer.sv
`default_nettype none
// ============================================================================
// Module  : control_leer
// Brief   : Read-side controller for the RTC multiplexed address/data bus.
//           Optionally sends the transfer command, then sweeps the six time
//           registers (address write + data read each) and holds the bytes
//           returned. Reports completion or a wait timeout with 1-cycle pulses.
// Revision: 1.0 - initial release
// ============================================================================
module control_leer
    import rtc_pkg::*;
#(
    parameter int HAB_TRANSFER = 1,
    parameter int T_ESPERA     = 255
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio_r,
    input  logic       fin_wr,
    input  logic [7:0] dato_in,
    output logic       inicio_wr,
    output logic       op_r,
    output logic       ad_r,
    output logic [7:0] bus_out,
    output logic       ocupado,
    output logic       fin_r,
    output logic       err_r,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio
);

    // The counter holds (cycles spent waiting - 1); reaching this value with
    // no fin_wr means T_ESPERA wait cycles have gone by.
    localparam logic [7:0] c_cuenta_max = 8'(T_ESPERA - 1);
    localparam estado_t    c_est_inicio = (HAB_TRANSFER != 0) ? c_est_tr_a : c_est_rd_a;

    estado_t    r_estado;
    estado_t    w_estado_sig;
    logic [2:0] r_idx;
    logic [7:0] r_cuenta;
    logic       w_en_espera;
    logic       w_en_pulso;
    logic       w_expira;
    logic       w_latch;

    logic [7:0] r_seg;
    logic [7:0] r_min;
    logic [7:0] r_hora;
    logic [7:0] r_dia;
    logic [7:0] r_mes;
    logic [7:0] r_anio;

    // Classify the current state and detect timeout / data-latch conditions
    always_comb begin
        w_en_espera = (r_estado == c_est_tr_wa) || (r_estado == c_est_tr_wd) ||
                      (r_estado == c_est_rd_wa) || (r_estado == c_est_rd_wd);
        w_en_pulso  = (r_estado == c_est_tr_a)  || (r_estado == c_est_tr_d)  ||
                      (r_estado == c_est_rd_a)  || (r_estado == c_est_rd_d);
        // fin_wr takes priority over an expiring counter
        w_expira    = w_en_espera && !fin_wr && (r_cuenta == c_cuenta_max);
        w_latch     = (r_estado == c_est_rd_wd) && fin_wr;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= c_est_idle;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state logic: request states last one cycle, wait states hold
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            c_est_idle: begin
                if (inicio_r) begin
                    w_estado_sig = c_est_inicio;
                end
            end
            c_est_tr_a:  w_estado_sig = c_est_tr_wa;
            c_est_tr_wa: begin
                if (fin_wr) begin
                    w_estado_sig = c_est_tr_d;
                end else if (w_expira) begin
                    w_estado_sig = c_est_err;
                end
            end
            c_est_tr_d:  w_estado_sig = c_est_tr_wd;
            c_est_tr_wd: begin
                if (fin_wr) begin
                    w_estado_sig = c_est_rd_a;
                end else if (w_expira) begin
                    w_estado_sig = c_est_err;
                end
            end
            c_est_rd_a:  w_estado_sig = c_est_rd_wa;
            c_est_rd_wa: begin
                if (fin_wr) begin
                    w_estado_sig = c_est_rd_d;
                end else if (w_expira) begin
                    w_estado_sig = c_est_err;
                end
            end
            c_est_rd_d:  w_estado_sig = c_est_rd_wd;
            c_est_rd_wd: begin
                if (fin_wr) begin
                    w_estado_sig = (r_idx == c_idx_ultimo) ? c_est_fin : c_est_rd_a;
                end else if (w_expira) begin
                    w_estado_sig = c_est_err;
                end
            end
            c_est_fin:   w_estado_sig = c_est_idle;
            c_est_err:   w_estado_sig = c_est_idle;
            default:     w_estado_sig = c_est_idle;
        endcase
    end

    // Sweep index: parked at 0 while idle, advanced after each latched byte
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= 3'd0;
        end else if (r_estado == c_est_idle) begin
            r_idx <= 3'd0;
        end else if (w_latch && (r_idx != c_idx_ultimo)) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // Timeout counter: every wait state is entered from a request state, so
    // clearing there starts each wait from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cuenta <= 8'd0;
        end else if (w_en_pulso) begin
            r_cuenta <= 8'd0;
        end else if (w_en_espera && !fin_wr) begin
            r_cuenta <= r_cuenta + 8'd1;
        end
    end

    // Data registers: only the register selected by the index is written
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg  <= 8'h00;
            r_min  <= 8'h00;
            r_hora <= 8'h00;
            r_dia  <= 8'h00;
            r_mes  <= 8'h00;
            r_anio <= 8'h00;
        end else if (w_latch) begin
            case (r_idx)
                3'd0:    r_seg  <= dato_in;
                3'd1:    r_min  <= dato_in;
                3'd2:    r_hora <= dato_in;
                3'd3:    r_dia  <= dato_in;
                3'd4:    r_mes  <= dato_in;
                3'd5:    r_anio <= dato_in;
                default: r_seg  <= r_seg;
            endcase
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        ocupado = (r_estado != c_est_idle);
        fin_r   = (r_estado == c_est_fin);
        err_r   = (r_estado == c_est_err);
        seg     = r_seg;
        min     = r_min;
        hora    = r_hora;
        dia     = r_dia;
        mes     = r_mes;
        anio    = r_anio;
    end

    deco_leer u_deco (
        .i_estado    (r_estado),
        .i_idx       (r_idx),
        .o_op_r      (op_r),
        .o_ad_r      (ad_r),
        .o_bus_out   (bus_out),
        .o_inicio_wr (inicio_wr)
    );

endmodule
`default_nettype wire

// File: tb/tb_control_leer.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_leer
// Brief   : Scoreboard bench for control_leer. Two instances: one with the
//           transfer command enabled, one without. A bus-cycle generator
//           model answers each request after a planned delay.
// Revision: 1.0 - initial release
// ============================================================================
module tb_control_leer;

    localparam int T = 10;

    typedef struct {
        logic        es_err;
        int          lat;
        logic [47:0] regs;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inicio_r = 1'b0;
    logic inicio_r_b = 1'b0;
    logic fin_wr = 1'b0;
    logic fin_wr_b = 1'b0;
    logic [7:0] dato_in = 8'h00;
    logic [7:0] dato_in_b = 8'h00;

    logic       inicio_wr, op_r, ad_r, ocupado, fin_r, err_r;
    logic [7:0] bus_out, seg, min, hora, dia, mes, anio;
    logic       inicio_wr_b, op_r_b, ad_r_b, ocupado_b, fin_r_b, err_r_b;
    logic [7:0] bus_out_b, seg_b, min_b, hora_b, dia_b, mes_b, anio_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int zero_req = 0, zero_done = 0;
    int to_req = 0, to_done = 0;

    logic [9:0]  q_a[$];
    logic [9:0]  q_b[$];
    ev_t         ev_a[$];
    ev_t         ev_b[$];
    logic [7:0]  mdl_a[6];
    logic [7:0]  dat_plan[6];
    int          dly_plan[6];
    logic [7:0]  dat_b[6];
    int          spur_k = -1;

    control_leer #(.HAB_TRANSFER(1), .T_ESPERA(T)) dut (
        .clk(clk), .reset(reset), .inicio_r(inicio_r), .fin_wr(fin_wr), .dato_in(dato_in),
        .inicio_wr(inicio_wr), .op_r(op_r), .ad_r(ad_r), .bus_out(bus_out),
        .ocupado(ocupado), .fin_r(fin_r), .err_r(err_r),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio)
    );

    control_leer #(.HAB_TRANSFER(0), .T_ESPERA(T)) dut_b (
        .clk(clk), .reset(reset), .inicio_r(inicio_r_b), .fin_wr(fin_wr_b), .dato_in(dato_in_b),
        .inicio_wr(inicio_wr_b), .op_r(op_r_b), .ad_r(ad_r_b), .bus_out(bus_out_b),
        .ocupado(ocupado_b), .fin_r(fin_r_b), .err_r(err_r_b),
        .seg(seg_b), .min(min_b), .hora(hora_b), .dia(dia_b), .mes(mes_b), .anio(anio_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus-cycle generator model for instance A: fin_wr arrives in the d-th
    // wait cycle after a request; d=0 withholds it.
    int         pend_a = 0;
    int         rdk_a = 0;
    logic [7:0] pdat_a = 8'h00;
    always @(negedge clk) begin
        fin_wr = 1'b0;
        dato_in = 8'($urandom);
        if (pend_a > 0) begin
            pend_a--;
            if (pend_a == 0) begin
                fin_wr = 1'b1;
                dato_in = pdat_a;
            end
        end
        if (inicio_wr) begin
            if (op_r && rdk_a < 6) begin
                pend_a = dly_plan[rdk_a];
                pdat_a = dat_plan[rdk_a];
                rdk_a++;
            end else begin
                pend_a = int'($urandom_range(1, 5));
            end
            if (spur_k == rdk_a && ad_r && !op_r && bus_out != 8'hF0) begin
                fin_wr = 1'b1;
                dato_in = 8'hEE;
            end
        end
        if (!ocupado || reset) begin
            rdk_a = 0;
            pend_a = 0;
        end
    end

    // Bus-cycle generator model for instance B: fixed 3-cycle answer
    int         pend_b = 0;
    int         rdk_b = 0;
    logic [7:0] pdat_b = 8'h00;
    always @(negedge clk) begin
        fin_wr_b = 1'b0;
        dato_in_b = 8'($urandom);
        if (pend_b > 0) begin
            pend_b--;
            if (pend_b == 0) begin
                fin_wr_b = 1'b1;
                dato_in_b = pdat_b;
            end
        end
        if (inicio_wr_b) begin
            pend_b = 3;
            if (op_r_b && rdk_b < 6) begin
                pdat_b = dat_b[rdk_b];
                rdk_b++;
            end
        end
        if (!ocupado_b || reset) begin
            rdk_b = 0;
            pend_b = 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm, input string msg);
        total++;
        bad++;
        $display("FAIL %s: %s (cycle %0d)", nm, msg, cyc);
    endtask

    // Monitor / scoreboard
    logic [9:0] last_a = '0;
    int         liw_a = 0, liw_b = 0;
    logic       idle_a = 1'b0, idle_b = 1'b0;
    logic [9:0] d;
    ev_t        e;
    always @(negedge clk) begin
        if (zero_req != zero_done) begin
            zero_done++;
            chk("reset_state_a", {2'b00, inicio_wr, op_r, ad_r, bus_out, ocupado, fin_r, err_r,
                                  seg, min, hora, dia, mes, anio}, 64'd0);
            chk("reset_state_b", {2'b00, inicio_wr_b, op_r_b, ad_r_b, bus_out_b, ocupado_b, fin_r_b,
                                  err_r_b, seg_b, min_b, hora_b, dia_b, mes_b, anio_b}, 64'd0);
        end
        if (to_req != to_done) begin
            to_done++;
            fail("wait_budget", "controller did not return to idle within the cycle budget");
        end
        // instance A
        if (inicio_wr) begin
            if (q_a.size() == 0) begin
                fail("extra_cycle_a", "bus cycle requested with none expected");
            end else begin
                d = q_a.pop_front();
                chk("bus_cycle_a", {op_r, ad_r, bus_out}, d);
                last_a = d;
                liw_a = cyc;
            end
        end else if (ocupado && !fin_r && !err_r) begin
            chk("hold_a", {op_r, ad_r, bus_out}, last_a);
        end
        if (fin_r || err_r) begin
            if (ev_a.size() == 0) begin
                fail("extra_end_a", "fin_r/err_r with no sweep expected");
            end else begin
                e = ev_a.pop_front();
                chk("end_kind_a", {fin_r, err_r}, e.es_err ? 2'b01 : 2'b10);
                chk("end_latency_a", 64'(cyc - liw_a), 64'(e.lat));
                chk("regs_a", {seg, min, hora, dia, mes, anio}, e.regs);
            end
            idle_a = 1'b1;
        end else if (idle_a) begin
            idle_a = 1'b0;
            chk("back_to_idle_a", {ocupado, fin_r, err_r}, 3'b000);
        end
        // instance B
        if (inicio_wr_b) begin
            if (q_b.size() == 0) begin
                fail("extra_cycle_b", "bus cycle requested with none expected");
            end else begin
                d = q_b.pop_front();
                chk("bus_cycle_b", {op_r_b, ad_r_b, bus_out_b}, d);
                liw_b = cyc;
            end
        end
        if (fin_r_b || err_r_b) begin
            if (ev_b.size() == 0) begin
                fail("extra_end_b", "fin_r/err_r with no sweep expected");
            end else begin
                e = ev_b.pop_front();
                chk("end_kind_b", {fin_r_b, err_r_b}, e.es_err ? 2'b01 : 2'b10);
                chk("end_latency_b", 64'(cyc - liw_b), 64'(e.lat));
                chk("regs_b", {seg_b, min_b, hora_b, dia_b, mes_b, anio_b}, e.regs);
            end
            idle_b = 1'b1;
        end else if (idle_b) begin
            idle_b = 1'b0;
            chk("back_to_idle_b", {ocupado_b, fin_r_b, err_r_b}, 3'b000);
        end
    end

    // Reference model for instance A: the bus cycles a sweep must produce,
    // the way it ends, and the register contents at that point
    task automatic expect_sweep_a();
        ev_t ev;
        ev.es_err = 1'b0;
        q_a.push_back({1'b0, 1'b1, 8'hF0});
        q_a.push_back({1'b0, 1'b0, 8'hF0});
        for (int k = 0; k < 6; k++) begin
            q_a.push_back({1'b0, 1'b1, 8'(8'h21 + k)});
            q_a.push_back({1'b1, 1'b0, 8'h00});
            if (dly_plan[k] == 0 || dly_plan[k] > T) begin
                ev.es_err = 1'b1;
                break;
            end
            mdl_a[k] = dat_plan[k];
        end
        ev.lat  = ev.es_err ? T + 1 : dly_plan[5] + 1;
        ev.regs = {mdl_a[0], mdl_a[1], mdl_a[2], mdl_a[3], mdl_a[4], mdl_a[5]};
        ev_a.push_back(ev);
    endtask

    task automatic expect_sweep_b();
        ev_t ev;
        for (int k = 0; k < 6; k++) begin
            q_b.push_back({1'b0, 1'b1, 8'(8'h21 + k)});
            q_b.push_back({1'b1, 1'b0, 8'h00});
        end
        ev.es_err = 1'b0;
        ev.lat    = 4;
        ev.regs   = {dat_b[0], dat_b[1], dat_b[2], dat_b[3], dat_b[4], dat_b[5]};
        ev_b.push_back(ev);
    endtask

    task automatic random_plan();
        for (int k = 0; k < 6; k++) begin
            dat_plan[k] = 8'($urandom);
            dly_plan[k] = int'($urandom_range(1, T));
        end
    endtask

    task automatic pulse(input bit a, input bit b);
        @(posedge clk); #1;
        inicio_r = a;
        inicio_r_b = b;
        @(posedge clk); #1;
        inicio_r = 1'b0;
        inicio_r_b = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(q_a.size() == 0 && ev_a.size() == 0 && q_b.size() == 0 &&
                     ev_b.size() == 0 && !ocupado && !ocupado_b) && n < 2000);
        if (n >= 2000) to_req++;
    endtask

    initial begin
        for (int k = 0; k < 6; k++) mdl_a[k] = 8'h00;

        // reset
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        zero_req++;
        @(negedge clk);

        // full sweep with transfer on A, no transfer on B
        dat_plan = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h04, 8'h16};
        dly_plan = '{3, 3, 3, 3, 3, 3};
        for (int k = 0; k < 6; k++) dat_b[k] = 8'($urandom);
        expect_sweep_a();
        expect_sweep_b();
        pulse(1'b1, 1'b1);
        wait_idle();

        // timeout on the third read data phase
        random_plan();
        dly_plan[2] = 0;
        expect_sweep_a();
        pulse(1'b1, 1'b0);
        wait_idle();

        // fin_wr on the last cycle before expiry still latches
        random_plan();
        dly_plan[4] = T;
        expect_sweep_a();
        pulse(1'b1, 1'b0);
        wait_idle();

        // inicio_r held through a sweep, plus a spurious fin_wr in RD_A
        random_plan();
        spur_k = 2;
        expect_sweep_a();
        expect_sweep_a();
        @(posedge clk); #1 inicio_r = 1'b1;
        begin
            int n = 0;
            while (ev_a.size() != 1 && n < 2000) begin
                @(negedge clk); #1;
                n++;
            end
            while (ocupado && n < 2000) begin
                @(negedge clk); #1;
                n++;
            end
            if (n >= 2000) to_req++;
        end
        @(posedge clk); #1 inicio_r = 1'b0;
        wait_idle();
        spur_k = -1;

        // reset while waiting in RD_WD of index 3
        random_plan();
        dly_plan[3] = 0;
        expect_sweep_a();
        pulse(1'b1, 1'b0);
        begin
            int n = 0;
            while (!(q_a.size() == 0 && ocupado) && n < 2000) begin
                @(negedge clk); #1;
                n++;
            end
            if (n >= 2000) to_req++;
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        q_a.delete();
        ev_a.delete();
        for (int k = 0; k < 6; k++) mdl_a[k] = 8'h00;
        zero_req++;
        @(negedge clk);

        // fresh sweeps after reset, random data and delays
        for (int s = 0; s < 4; s++) begin
            random_plan();
            expect_sweep_a();
            pulse(1'b1, 1'b0);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
